m68k_region_decoder: RTL and testbench
======================================

// Module: m68k_region_decoder
// PURPOSE
//  Parametrised, runtime-programmable address decoder for the 68K side of the board.
//  Maps the bus onto NUM_REGIONS chip selects from a base/mask table loaded by the loader.
//  Generates DTACK_n after a per-region wait count, and BERR_n when an unmapped cycle times out.
//  Replaces per-PCB hard-coded decode; sits between the 68K core and the memory/IO selects.
// PARAMETERS
//  NUM_REGIONS  16  number of decode regions / chip-select outputs
//  ADDR_W       24  bus address width
//  WAIT_W        4  width of per-region wait-state count
//  TIMEOUT      64  clk cycles before BERR_n on an unmapped cycle (>=2)
// PORTS
//  clk        in   1              system clock
//  reset_n    in   1              async active-low reset
//  cfg_we     in   1              write one table entry this cycle
//  cfg_idx    in   $clog2(NUM_REGIONS)  entry index
//  cfg_en     in   1              entry enable
//  cfg_base   in   ADDR_W         entry base address
//  cfg_mask   in   ADDR_W         entry compare mask (1 = compared bit)
//  cfg_wait   in   WAIT_W         entry wait states before DTACK
//  cfg_rw_en  in   2              [0] read allowed, [1] write allowed
//  bus_a      in   ADDR_W         68K address
//  bus_as_n   in   1              68K address strobe, active low
//  bus_rw     in   1              1 = read, 0 = write
//  cs         out  NUM_REGIONS    registered one-hot chip selects
//  hit_idx    out  $clog2(NUM_REGIONS)  index of the active region
//  dtack_n    out  1              data acknowledge, active low
//  berr_n     out  1              bus error, active low
//  busy       out  1              high while a bus cycle is in progress
// BEHAVIOUR
//  Reset (async): all table entries disabled, cs=0, hit_idx=0, dtack_n=1, berr_n=1, busy=0, state IDLE.
//  Match(i) = en[i] & ((bus_a ^ base[i]) & mask[i]) == 0 & rw_en[i][bus_rw ? 0 : 1].
//  Priority: the lowest matching index wins. cs is always one-hot or zero.
//  FSM states: IDLE, WAIT, ACK, ERR.
//   IDLE: when bus_as_n is sampled low, evaluate the match on that edge.
//    - Hit: cs[k]=1, hit_idx=k, busy=1; load the counter with wait[k]. Go to ACK if wait[k]=0, else WAIT.
//    - Miss: cs stays 0, busy=1; load the counter with TIMEOUT-1; go to ERR-pending (WAIT with miss flag).
//   WAIT: decrement the counter each clk.
//    - Hit, counter reaches 0: dtack_n=0 on the next edge (ACK).
//    - Miss, counter reaches 0: berr_n=0 (ERR).
//   ACK / ERR: hold dtack_n (or berr_n) and cs until bus_as_n is sampled high.
//    Then on that same edge: cs=0, dtack_n=1, berr_n=1, busy=0, go to IDLE.
//  Latency: cs at edge +1 after AS low; dtack_n at edge +1+wait; berr_n at edge +TIMEOUT.
//  AS deasserts during WAIT (abort): on the next edge return to IDLE, clear cs, never assert dtack_n/berr_n.
//  Back-to-back cycles: AS must be seen high for at least 1 clk. A new cycle decodes on the first low sample after IDLE.
//  Config timing:
//   - Table writes take effect the clk after cfg_we.
//   - A cycle already decoded keeps its latched region and wait count, even if its entry is rewritten mid-cycle.
//   - A cfg write and a decode on the same edge: the decode uses the old entry.
//  Address and rw are sampled only at decode; later changes are ignored until IDLE.
//  dtack_n and berr_n are never both low.
// TESTING
//  T1: after reset, AS low at 0x000100 with no entries -> cs=0; berr_n low exactly TIMEOUT clks after decode; released on AS high.
//  T2: entry0 base 0x000000 mask 0xFC0000 wait 0; AS at 0x03FFFE -> cs=0x0001 at +1, dtack_n low at +1.
//  T3: entry3 base 0x400000 mask 0xFFE000 wait 3, entry5 overlapping; access 0x400010 -> cs[3] only; dtack_n low at +4.
//  T4: entry with wait 7; AS raised after 2 clks -> cs cleared next clk; dtack_n and berr_n stay high; next cycle decodes normally.
//  T5: write-only entry, read access -> miss, berr_n. Rewrite the entry during a WAIT -> current cycle completes with the old wait.
//  T6: assert reset_n low in ACK -> cs=0, dtack_n=1, table cleared immediately, without waiting for clk.

Source files
------------

// File: rtl/m68k_region_decoder.sv
// Runtime-programmable 68K address decoder: base/mask region table, one-hot chip
// selects, per-region DTACK wait states and a bus-error timeout for unmapped cycles.
module m68k_region_decoder #(
  parameter int NUM_REGIONS = 16,
  parameter int ADDR_W      = 24,
  parameter int WAIT_W      = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_REGIONS)-1:0] cfg_idx,
  input  logic                           cfg_en,
  input  logic [ADDR_W-1:0]              cfg_base,
  input  logic [ADDR_W-1:0]              cfg_mask,
  input  logic [WAIT_W-1:0]              cfg_wait,
  input  logic [1:0]                     cfg_rw_en,
  input  logic [ADDR_W-1:0]              bus_a,
  input  logic                           bus_as_n,
  input  logic                           bus_rw,
  output logic [NUM_REGIONS-1:0]         cs,
  output logic [$clog2(NUM_REGIONS)-1:0] hit_idx,
  output logic                           dtack_n,
  output logic                           berr_n,
  output logic                           busy
);

  localparam int IDX_W = $clog2(NUM_REGIONS);
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam int CNT_W = (WAIT_W > TO_W) ? WAIT_W : TO_W;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;

  logic              en_q   [NUM_REGIONS];
  logic [ADDR_W-1:0] base_q [NUM_REGIONS];
  logic [ADDR_W-1:0] mask_q [NUM_REGIONS];
  logic [WAIT_W-1:0] wait_q [NUM_REGIONS];
  logic [1:0]        rwen_q [NUM_REGIONS];

  state_t                 state_q, state_d;
  logic [NUM_REGIONS-1:0] cs_q, cs_d;
  logic [IDX_W-1:0]       hit_idx_q, hit_idx_d;
  logic                   dtack_n_q, dtack_n_d;
  logic                   berr_n_q, berr_n_d;
  logic                   busy_q, busy_d;
  logic                   miss_q, miss_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   match_found;
  logic [IDX_W-1:0]       match_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        en_q[i]   <= 1'b0;
        base_q[i] <= '0;
        mask_q[i] <= '0;
        wait_q[i] <= '0;
        rwen_q[i] <= '0;
      end
    end else if (cfg_we) begin
      en_q[cfg_idx]   <= cfg_en;
      base_q[cfg_idx] <= cfg_base;
      mask_q[cfg_idx] <= cfg_mask;
      wait_q[cfg_idx] <= cfg_wait;
      rwen_q[cfg_idx] <= cfg_rw_en;
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (en_q[i] && (((bus_a ^ base_q[i]) & mask_q[i]) == '0) &&
          rwen_q[i][bus_rw ? 1'b0 : 1'b1]) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cs_q      <= '0;
      hit_idx_q <= '0;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      busy_q    <= 1'b0;
      miss_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      hit_idx_q <= hit_idx_d;
      dtack_n_q <= dtack_n_d;
      berr_n_q  <= berr_n_d;
      busy_q    <= busy_d;
      miss_q    <= miss_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cs_d      = cs_q;
    hit_idx_d = hit_idx_q;
    dtack_n_d = dtack_n_q;
    berr_n_d  = berr_n_q;
    busy_d    = busy_q;
    miss_d    = miss_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (!bus_as_n) begin
          busy_d = 1'b1;
          if (match_found) begin
            cs_d      = NUM_REGIONS'(1) << match_idx;
            hit_idx_d = match_idx;
            miss_d    = 1'b0;
            if (wait_q[match_idx] == '0) begin
              state_d   = ACK;
              dtack_n_d = 1'b0;
            end else begin
              state_d = WAIT;
              cnt_d   = CNT_W'(wait_q[match_idx]);
            end
          end else begin
            cs_d      = '0;
            hit_idx_d = '0;
            miss_d    = 1'b1;
            state_d   = WAIT;
            cnt_d     = CNT_W'(TIMEOUT - 1);
          end
        end
      end
      WAIT: begin
        // An early AS release aborts quietly: no DTACK and no BERR.
        if (bus_as_n) begin
          state_d = IDLE;
          cs_d    = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_W'(1)) begin
          if (miss_q) begin
            state_d  = ERR;
            berr_n_d = 1'b0;
          end else begin
            state_d   = ACK;
            dtack_n_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK, ERR: begin
        if (bus_as_n) begin
          state_d   = IDLE;
          cs_d      = '0;
          dtack_n_d = 1'b1;
          berr_n_d  = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cs      = cs_q;
  assign hit_idx = hit_idx_q;
  assign dtack_n = dtack_n_q;
  assign berr_n  = berr_n_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_m68k_region_decoder.sv
// Scoreboard bench for m68k_region_decoder: stimulus queues timed expected output
// vectors, a negedge monitor pops one per observed output change and compares.
module tb_m68k_region_decoder;

  localparam int NR = 16;
  localparam int AW = 24;
  localparam int WW = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cfg_we;
  logic [3:0]    cfg_idx;
  logic          cfg_en;
  logic [AW-1:0] cfg_base;
  logic [AW-1:0] cfg_mask;
  logic [WW-1:0] cfg_wait;
  logic [1:0]    cfg_rw_en;
  logic [AW-1:0] bus_a;
  logic          bus_as_n;
  logic          bus_rw;
  logic [NR-1:0] cs;
  logic [3:0]    hit_idx;
  logic          dtack_n;
  logic          berr_n;
  logic          busy;

  m68k_region_decoder #(.NUM_REGIONS(NR), .ADDR_W(AW), .WAIT_W(WW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_base(cfg_base), .cfg_mask(cfg_mask), .cfg_wait(cfg_wait), .cfg_rw_en(cfg_rw_en),
    .bus_a(bus_a), .bus_as_n(bus_as_n), .bus_rw(bus_rw), .cs(cs), .hit_idx(hit_idx),
    .dtack_n(dtack_n), .berr_n(berr_n), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [22:0] vec;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [22:0] prev = {16'h0000, 4'h0, 1'b1, 1'b1, 1'b0};
  logic [22:0] cur;
  exp_t        ex;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output vector must match the next queued expectation.
  always @(negedge clk) begin
    cur = {cs, hit_idx, dtack_n, berr_n, busy};
    if (cur !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
      end else begin
        ex = q.pop_front();
        if (ex.vec !== cur || ex.cyc != cyc) begin
          errors++;
          $display("FAIL %s got cyc=%0d vec=%h, want cyc=%0d vec=%h",
                   ex.name, cyc, cur, ex.cyc, ex.vec);
        end
      end
      prev = cur;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask

  task automatic push(input int at, input logic [15:0] c, input logic [3:0] h,
                      input logic d, input logic b, input logic y, input string n);
    exp_t e;
    e.cyc  = at;
    e.vec  = {c, h, d, b, y};
    e.name = n;
    q.push_back(e);
  endtask

  task automatic cfg(input int idx, input logic en, input logic [AW-1:0] base,
                     input logic [AW-1:0] mask, input int w, input logic [1:0] rwen);
    cfg_idx   = 4'(idx);
    cfg_en    = en;
    cfg_base  = base;
    cfg_mask  = mask;
    cfg_wait  = WW'(w);
    cfg_rw_en = rwen;
    cfg_we    = 1'b1;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic access_hit(input logic [AW-1:0] a, input logic rw, input int k,
                            input int w, input string n);
    int c;
    int e;
    logic [15:0] oh;
    oh = 16'(1) << k;
    c = cyc;
    bus_a = a;
    bus_rw = rw;
    bus_as_n = 1'b0;
    if (w == 0) begin
      push(c + 1, oh, 4'(k), 1'b0, 1'b1, 1'b1, {n, "_decode_ack"});
    end else begin
      push(c + 1, oh, 4'(k), 1'b1, 1'b1, 1'b1, {n, "_decode"});
      push(c + 1 + w, oh, 4'(k), 1'b0, 1'b1, 1'b1, {n, "_dtack"});
    end
    repeat (w + 2) step();
    e = cyc;
    bus_as_n = 1'b1;
    push(e + 1, 16'h0000, 4'(k), 1'b1, 1'b1, 1'b0, {n, "_release"});
    repeat (2) step();
  endtask

  // Any cfg write set up by the caller lands on the decode edge, then is dropped.
  task automatic access_miss(input logic [AW-1:0] a, input logic rw, input string n);
    int c;
    int e;
    c = cyc;
    bus_a = a;
    bus_rw = rw;
    bus_as_n = 1'b0;
    push(c + 1, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b1, {n, "_decode"});
    push(c + TO, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b1, {n, "_berr"});
    step();
    cfg_we = 1'b0;
    repeat (TO) step();
    e = cyc;
    bus_as_n = 1'b1;
    push(e + 1, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b0, {n, "_release"});
    repeat (2) step();
  endtask

  initial begin
    int c;
    int e;
    reset_n = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_base = '0; cfg_mask = '0;
    cfg_wait = '0; cfg_rw_en = '0;
    bus_a = '0; bus_as_n = 1'b1; bus_rw = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    cmp("rst_cs", 32'(cs), 32'h0);
    cmp("rst_hit_idx", 32'(hit_idx), 32'h0);
    cmp("rst_dtack_n", 32'(dtack_n), 32'h1);
    cmp("rst_berr_n", 32'(berr_n), 32'h1);
    cmp("rst_busy", 32'(busy), 32'h0);

    access_miss(24'h000100, 1'b1, "t1_empty_table");

    cfg(0, 1'b1, 24'h000000, 24'hFC0000, 0, 2'b11);
    access_hit(24'h03FFFE, 1'b1, 0, 0, "t2_entry0");

    cfg(3, 1'b1, 24'h400000, 24'hFFE000, 3, 2'b11);
    cfg(5, 1'b1, 24'h400000, 24'hFF0000, 1, 2'b11);
    access_hit(24'h400010, 1'b1, 3, 3, "t3_overlap_lowest");
    access_hit(24'h40F000, 1'b0, 5, 1, "t3_entry5_only");

    cfg(7, 1'b1, 24'h800000, 24'hFF0000, 7, 2'b11);
    c = cyc;
    bus_a = 24'h800004; bus_rw = 1'b1; bus_as_n = 1'b0;
    push(c + 1, 16'h0080, 4'd7, 1'b1, 1'b1, 1'b1, "t4_decode");
    repeat (2) step();
    bus_as_n = 1'b1;
    push(c + 3, 16'h0000, 4'd7, 1'b1, 1'b1, 1'b0, "t4_abort");
    repeat (10) step();
    access_hit(24'h800004, 1'b1, 7, 7, "t4_after_abort");

    cfg(9, 1'b1, 24'hA00000, 24'hFF0000, 2, 2'b10);
    access_miss(24'hA00000, 1'b1, "t5_read_of_wo");
    access_hit(24'hA00010, 1'b0, 9, 2, "t5_write_of_wo");

    c = cyc;
    bus_a = 24'h800000; bus_rw = 1'b1; bus_as_n = 1'b0;
    push(c + 1, 16'h0080, 4'd7, 1'b1, 1'b1, 1'b1, "t5_rw_decode");
    push(c + 8, 16'h0080, 4'd7, 1'b0, 1'b1, 1'b1, "t5_rw_old_wait");
    step();
    cfg(7, 1'b1, 24'h800000, 24'hFF0000, 1, 2'b11);
    repeat (8) step();
    e = cyc;
    bus_as_n = 1'b1;
    push(e + 1, 16'h0000, 4'd7, 1'b1, 1'b1, 1'b0, "t5_rw_release");
    repeat (2) step();
    access_hit(24'h800000, 1'b1, 7, 1, "t5_new_wait");

    cfg_idx = 4'd2; cfg_en = 1'b1; cfg_base = 24'hC00000; cfg_mask = 24'hFF0000;
    cfg_wait = '0; cfg_rw_en = 2'b11; cfg_we = 1'b1;
    access_miss(24'hC00000, 1'b1, "cfg_same_edge_old");
    access_hit(24'hC00000, 1'b1, 2, 0, "cfg_after_write");

    c = cyc;
    bus_a = 24'h000010; bus_rw = 1'b1; bus_as_n = 1'b0;
    push(c + 1, 16'h0001, 4'd0, 1'b0, 1'b1, 1'b1, "t6_decode_ack");
    repeat (2) step();
    #2;
    reset_n = 1'b0;
    push(cyc, 16'h0000, 4'd0, 1'b1, 1'b1, 1'b0, "t6_async_reset");
    #1;
    cmp("t6_cs_immediate", 32'(cs), 32'h0);
    cmp("t6_dtack_n_immediate", 32'(dtack_n), 32'h1);
    cmp("t6_busy_immediate", 32'(busy), 32'h0);
    bus_as_n = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    access_miss(24'h000010, 1'b1, "t6_table_cleared");

    repeat (3) step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
